// File: rtl/seven_seg_scanner.sv
// ----------------------------------------------------------------------------
// seven_seg_scanner: time-multiplexed N-digit common-anode hex display driver
// with per-slot blanking and frame-synchronous double buffering.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seven_seg_scanner #(
  parameter int N_DIGITS     = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  load,
  output logic                  pending,
  output logic [N_DIGITS-1:0]   AN,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic                  frame_tick
);

  localparam int c_cnt_w = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int c_idx_w = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SLOT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_blank    = c_cnt_w'(BLANK_CYCLES);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N_DIGITS - 1);

  function automatic logic [6:0] f_decode(input logic [3:0] n);
    case (n)
      4'h0: f_decode = 7'h40;  4'h1: f_decode = 7'h79;
      4'h2: f_decode = 7'h24;  4'h3: f_decode = 7'h30;
      4'h4: f_decode = 7'h19;  4'h5: f_decode = 7'h12;
      4'h6: f_decode = 7'h02;  4'h7: f_decode = 7'h78;
      4'h8: f_decode = 7'h00;  4'h9: f_decode = 7'h10;
      4'hA: f_decode = 7'h08;  4'hB: f_decode = 7'h03;
      4'hC: f_decode = 7'h46;  4'hD: f_decode = 7'h21;
      4'hE: f_decode = 7'h06;  4'hF: f_decode = 7'h0E;
      default: f_decode = 7'h7F;
    endcase
  endfunction

  logic [c_cnt_w-1:0]    cnt_q, cnt_d;
  logic [c_idx_w-1:0]    idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pval_q, pval_d, aval_q, aval_d;
  logic [N_DIGITS-1:0]   pdp_q, pdp_d, adp_q, adp_d;
  logic [N_DIGITS-1:0]   pen_q, pen_d, aen_q, aen_d;
  logic                  flag_q, flag_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  tick_q, tick_d;

  logic                  cnt_wrap;
  logic                  frame_end;
  logic                  drive;
  logic [3:0]            nibble;

  always_comb begin
    cnt_wrap  = (cnt_q == c_cnt_last);
    frame_end = cnt_wrap && (idx_q == c_idx_last);
    nibble    = aval_q[{idx_q, 2'b00} +: 4];
    // A disabled digit looks identical to the blanking phase.
    drive     = (cnt_q >= c_blank) && aen_q[idx_q];

    cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_wrap) idx_d = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;

    pval_d = load ? value    : pval_q;
    pdp_d  = load ? dp       : pdp_q;
    pen_d  = load ? digit_en : pen_q;
    // A load on the swap edge re-arms the flag for the following frame.
    flag_d = load | (flag_q & ~frame_end);

    aval_d = aval_q;
    adp_d  = adp_q;
    aen_d  = aen_q;
    if (frame_end && flag_q) begin
      aval_d = pval_q;
      adp_d  = pdp_q;
      aen_d  = pen_q;
    end

    an_d   = '1;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (drive) begin
      an_d  = ~(N_DIGITS'(1) << idx_q);
      seg_d = f_decode(nibble);
      dp_d  = ~adp_q[idx_q];
    end
    tick_d = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pval_q <= '0;
      pdp_q  <= '0;
      pen_q  <= '0;
      aval_q <= '0;
      adp_q  <= '0;
      aen_q  <= '0;
      flag_q <= 1'b0;
      an_q   <= '1;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pval_q <= pval_d;
      pdp_q  <= pdp_d;
      pen_q  <= pen_d;
      aval_q <= aval_d;
      adp_q  <= adp_d;
      aen_q  <= aen_d;
      flag_q <= flag_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      tick_q <= tick_d;
    end
  end

  assign pending    = flag_q;
  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign frame_tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with N_DIGITS=4, SLOT=8, BLANK=2.
`default_nettype none

module tb_seven_seg_scanner;

  localparam int N  = 4;
  localparam int SL = 8;
  localparam int BL = 2;
  localparam int FR = N * SL;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [15:0]  value = '0;
  logic [3:0]   dp = '0;
  logic [3:0]   digit_en = '0;
  logic         load = 1'b0;
  logic         pending;
  logic [3:0]   AN;
  logic [6:0]   SEG;
  logic         DP;
  logic         frame_tick;

  int passed = 0;
  int total  = 0;
  int ecount;

  seven_seg_scanner #(
    .N_DIGITS(N), .SLOT_CYCLES(SL), .BLANK_CYCLES(BL)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .digit_en(digit_en),
    .load(load), .pending(pending), .AN(AN), .SEG(SEG), .DP(DP),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Edge number since reset release: edge 1 is the first posedge with rst low.
  always @(posedge clk or posedge rst)
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;

  typedef struct {
    int          e;
    logic        ld;
    logic [15:0] val;
    logic [3:0]  dpi;
    logic [3:0]  en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpo;
    logic        pend;
  } vec_t;

  vec_t vecs[$];

  logic [6:0] dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic vec_t V(int e, logic ld, logic [15:0] val, logic [3:0] dpi,
                             logic [3:0] en, logic [3:0] an, logic [6:0] seg,
                             logic dpo, logic pend);
    vec_t v;
    v.e = e; v.ld = ld; v.val = val; v.dpi = dpi; v.en = en;
    v.an = an; v.seg = seg; v.dpo = dpo; v.pend = pend;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic advance_to(input int k);
    while (ecount < k) step();
  endtask

  task automatic check(input string nm, input int k, input logic [13:0] exp);
    logic [13:0] got;
    got = {AN, SEG, DP, frame_tick, pending};
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s edge %0d: got AN=%h SEG=%h DP=%b tick=%b pend=%b, want AN=%h SEG=%h DP=%b tick=%b pend=%b",
                  nm, k, got[13:10], got[9:3], got[2], got[1], got[0],
                  exp[13:10], exp[9:3], exp[2], exp[1], exp[0]);
  endtask

  task automatic do_load(input logic [15:0] val, input logic [3:0] dpi, input logic [3:0] en);
    value = val; dp = dpi; digit_en = en; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  function automatic logic tick_at(int k);
    return (k % FR) == 1;
  endfunction

  initial begin
    // Idle, scan order, frame-boundary swap, simultaneous load+swap.
    vecs.push_back(V(  1, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(V(  2, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(V(  4, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(V( 33, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(V( 34, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(V( 40, 1, 16'h8421, 4'h4, 4'hF, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(V( 43, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(V( 64, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(V( 65, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(V( 66, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(V( 67, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 7'h79, 1, 0));
    vecs.push_back(V( 72, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 7'h79, 1, 0));
    vecs.push_back(V( 73, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(V( 75, 0, 16'h0000, 4'h0, 4'h0, 4'hD, 7'h24, 1, 0));
    vecs.push_back(V( 83, 0, 16'h0000, 4'h0, 4'h0, 4'hB, 7'h19, 0, 0));
    vecs.push_back(V( 88, 0, 16'h0000, 4'h0, 4'h0, 4'hB, 7'h19, 0, 0));
    vecs.push_back(V( 89, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(V( 91, 0, 16'h0000, 4'h0, 4'h0, 4'h7, 7'h00, 1, 0));
    vecs.push_back(V( 96, 0, 16'h0000, 4'h0, 4'h0, 4'h7, 7'h00, 1, 0));
    vecs.push_back(V( 97, 0, 16'h0000, 4'h0, 4'h0, 4'hF, 7'h7F, 1, 0));
    vecs.push_back(V(100, 1, 16'h1111, 4'h0, 4'hF, 4'hE, 7'h79, 1, 1));
    vecs.push_back(V(128, 0, 16'h0000, 4'h0, 4'h0, 4'h7, 7'h00, 1, 0));
    vecs.push_back(V(131, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 7'h79, 1, 0));
    vecs.push_back(V(140, 1, 16'hFFFF, 4'h0, 4'hF, 4'hD, 7'h79, 1, 1));
    vecs.push_back(V(143, 0, 16'h0000, 4'h0, 4'h0, 4'hD, 7'h79, 1, 1));
    vecs.push_back(V(151, 0, 16'h0000, 4'h0, 4'h0, 4'hB, 7'h79, 1, 1));
    vecs.push_back(V(159, 0, 16'h0000, 4'h0, 4'h0, 4'h7, 7'h79, 1, 1));
    vecs.push_back(V(160, 0, 16'h0000, 4'h0, 4'h0, 4'h7, 7'h79, 1, 0));
    vecs.push_back(V(163, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 7'h0E, 1, 0));
    vecs.push_back(V(170, 1, 16'h5555, 4'h0, 4'hF, 4'hF, 7'h7F, 1, 1));
    vecs.push_back(V(171, 0, 16'h0000, 4'h0, 4'h0, 4'hD, 7'h0E, 1, 1));
    vecs.push_back(V(192, 1, 16'hAAAA, 4'h0, 4'hF, 4'h7, 7'h0E, 1, 1));
    vecs.push_back(V(195, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 7'h12, 1, 1));
    vecs.push_back(V(203, 0, 16'h0000, 4'h0, 4'h0, 4'hD, 7'h12, 1, 1));
    vecs.push_back(V(224, 0, 16'h0000, 4'h0, 4'h0, 4'h7, 7'h12, 1, 0));
    vecs.push_back(V(227, 0, 16'h0000, 4'h0, 4'h0, 4'hE, 7'h08, 1, 0));
    vecs.push_back(V(235, 0, 16'h0000, 4'h0, 4'h0, 4'hD, 7'h08, 1, 0));

    // Reset held for 3 cycles; outputs must sit at their reset values.
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", 0, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;

    foreach (vecs[i]) begin
      advance_to(vecs[i].e - 1);
      if (vecs[i].ld) do_load(vecs[i].val, vecs[i].dpi, vecs[i].en);
      else step();
      check("vector", vecs[i].e,
            {vecs[i].an, vecs[i].seg, vecs[i].dpo, tick_at(vecs[i].e), vecs[i].pend});
    end

    // Full decode on digit 0 only; other digits hold data but stay disabled.
    for (int v = 0; v < 16; v++) begin
      logic [3:0] nib;
      nib = 4'(v);
      advance_to(240 + FR * v - 1);
      do_load({4{nib}}, 4'hF, 4'b0001);
      advance_to(259 + FR * v);
      check("decode_dig0", ecount, {4'hE, dec_tbl[v], 1'b0, 1'b0, 1'b0});
      advance_to(267 + FR * v);
      check("decode_dig1_off", ecount, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    end

    // Async reset while digit 2 is being driven and an update is pending.
    advance_to(749);
    do_load(16'h1234, 4'h0, 4'hF);
    advance_to(779);
    do_load(16'h5678, 4'h0, 4'hF);
    advance_to(789);
    check("pre_reset_drive", ecount, {4'hB, 7'h24, 1'b1, 1'b0, 1'b1});
    #1 rst = 1'b1;
    #1 check("async_reset", -1, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_reset_tick", ecount, {4'hF, 7'h7F, 1'b1, 1'b1, 1'b0});
    advance_to(3);
    check("post_reset_blank", ecount, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    advance_to(11);
    check("post_reset_dig1", ecount, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
